regfile_sb_bypass: RTL and testbench

Parametrised successor to the pipeline's general-purpose register file. It provides N_RD_PORTS asynchronous read ports and one synchronous write port. After reset it runs a hardware clear sweep of every entry. It keeps a per-register pending-load scoreboard so decode can stall on load-use hazards. Sits in the decode stage: written by writeback, read by decode, and its busy bits feed the hazard unit.

---
 rtl/regfile_sb_bypass.sv | 179 +++++++++++++++++
 tb/tb_regfile_sb_bypass.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb_bypass.sv
// regfile_sb_bypass: general-purpose register file for the decode stage.
//   - N_RD_PORTS combinational read ports, one synchronous write port.
//   - After reset, a hardware sweep writes zero to every entry, one entry per
//     clock. ready rises once the sweep has covered the whole array.
//   - A per-register pending-load scoreboard. A load issue sets the busy bit
//     and writeback clears it. If both hit the same register, the set wins.
//   - Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb_bypass #(
    parameter int INDEX_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH  = 32,
    parameter int N_REGS          = (1 << INDEX_BIT_WIDTH),
    parameter int N_RD_PORTS      = 2,
    parameter int R0_ZERO         = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wrt_en,
    input  logic [INDEX_BIT_WIDTH-1:0]            wrt_index,
    input  logic [DATA_BIT_WIDTH-1:0]             wrt_data,
    input  logic                                  ld_issue,
    input  logic [INDEX_BIT_WIDTH-1:0]            ld_index,
    input  logic [N_RD_PORTS*INDEX_BIT_WIDTH-1:0] rd_index,
    output logic [N_RD_PORTS*DATA_BIT_WIDTH-1:0]  rd_data,
    output logic [N_RD_PORTS-1:0]                 rd_busy,
    output logic                                  ready
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [INDEX_BIT_WIDTH-1:0] LAST_IDX = INDEX_BIT_WIDTH'(N_REGS - 1);

    // Register 0 is a hardwired zero when R0_ZERO is set.
    function automatic logic f_is_hardwired_zero(input logic [INDEX_BIT_WIDTH-1:0] idx);
        return (R0_ZERO != 0) && (idx == {INDEX_BIT_WIDTH{1'b0}});
    endfunction

    // Indices beyond the implemented array are treated as absent.
    function automatic logic f_in_range(input logic [INDEX_BIT_WIDTH-1:0] idx);
        return (int'(idx) < N_REGS);
    endfunction

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [INDEX_BIT_WIDTH-1:0]  r_cnt;
    logic [INDEX_BIT_WIDTH-1:0]  w_cnt_nxt;
    logic                        r_ready;
    logic                        w_ready_nxt;
    logic [N_REGS-1:0]           r_busy;
    logic [N_REGS-1:0]           w_busy_nxt;
    logic [DATA_BIT_WIDTH-1:0]   r_mem [N_REGS];

    logic                        w_mem_we;
    logic [INDEX_BIT_WIDTH-1:0]  w_mem_idx;
    logic [DATA_BIT_WIDTH-1:0]   w_mem_dat;

    // Sweep control: advance one entry per edge in INIT, then stay in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_nxt = r_ready;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = {INDEX_BIT_WIDTH{1'b0}};
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = r_cnt + INDEX_BIT_WIDTH'(1);
                    w_ready_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = r_cnt;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = {INDEX_BIT_WIDTH{1'b0}};
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // Control state registers, including the scoreboard, with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= {INDEX_BIT_WIDTH{1'b0}};
            r_ready <= 1'b0;
            r_busy  <= {N_REGS{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Array write port: zero sweep in INIT, writeback in RUN.
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = r_cnt;
        w_mem_dat = {DATA_BIT_WIDTH{1'b0}};
        if (r_state == ST_INIT) begin
            w_mem_we  = f_in_range(r_cnt);
            w_mem_idx = r_cnt;
            w_mem_dat = {DATA_BIT_WIDTH{1'b0}};
        end else if (wrt_en && !f_is_hardwired_zero(wrt_index) && f_in_range(wrt_index)) begin
            w_mem_we  = 1'b1;
            w_mem_idx = wrt_index;
            w_mem_dat = wrt_data;
        end else begin
            w_mem_we  = 1'b0;
            w_mem_idx = r_cnt;
            w_mem_dat = {DATA_BIT_WIDTH{1'b0}};
        end
    end

    // Storage array. It has no reset; the post-reset sweep clears it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_dat;
        end
    end

    // Scoreboard next state. A load issue takes priority over writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < N_REGS; i++) begin
            if ((i == 0) && (R0_ZERO != 0)) begin
                w_busy_nxt[i] = 1'b0;
            end else if ((r_state == ST_RUN) && ld_issue && (int'(ld_index) == i)) begin
                w_busy_nxt[i] = 1'b1;
            end else if ((r_state == ST_RUN) && wrt_en && (int'(wrt_index) == i)) begin
                w_busy_nxt[i] = 1'b0;
            end else begin
                w_busy_nxt[i] = r_busy[i];
            end
        end
    end

    // Combinational read ports with zero-register, INIT masking and optional forwarding.
    always_comb begin
        logic [INDEX_BIT_WIDTH-1:0] v_idx;
        v_idx   = {INDEX_BIT_WIDTH{1'b0}};
        rd_data = {(N_RD_PORTS*DATA_BIT_WIDTH){1'b0}};
        rd_busy = {N_RD_PORTS{1'b0}};
        for (int p = 0; p < N_RD_PORTS; p++) begin
            v_idx = rd_index[p*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH];
            if (r_state != ST_RUN) begin
                rd_data[p*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = {DATA_BIT_WIDTH{1'b0}};
                rd_busy[p] = 1'b0;
            end else if (f_is_hardwired_zero(v_idx)) begin
                rd_data[p*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = {DATA_BIT_WIDTH{1'b0}};
                rd_busy[p] = 1'b0;
`ifdef RF_BYPASS_EN
            end else if (wrt_en && (wrt_index == v_idx)) begin
                // The result arriving this cycle is forwarded, so the load is no longer pending.
                rd_data[p*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = wrt_data;
                rd_busy[p] = 1'b0;
`endif
            end else if (f_in_range(v_idx)) begin
                rd_data[p*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = r_mem[v_idx];
                rd_busy[p] = r_busy[v_idx];
            end else begin
                rd_data[p*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = {DATA_BIT_WIDTH{1'b0}};
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign ready = r_ready;

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Self-checking bench for regfile_sb_bypass (default parameters).
// A behavioural model tracks register contents, pending loads and sweep progress.
// The model is compared against the DUT on every falling edge.
// Directed steps add literal expectations.
module tb_regfile_sb_bypass;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrt_en;
    logic [3:0]  wrt_index;
    logic [31:0] wrt_data;
    logic        ld_issue;
    logic [3:0]  ld_index;
    logic [7:0]  rd_index;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        ready;

    int total = 0;
    int bad   = 0;

    regfile_sb_bypass dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt_en    (wrt_en),
        .wrt_index (wrt_index),
        .wrt_data  (wrt_data),
        .ld_issue  (ld_issue),
        .ld_index  (ld_index),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [16];
    logic [15:0] m_busy  = 16'h0000;
    int          m_edges = 0;
    logic        m_ready = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 16'h0000;
            m_edges <= 0;
            m_ready <= 1'b0;
        end else if (!m_ready) begin
            m_mem[m_edges] <= 32'h0;
            m_edges        <= m_edges + 1;
            m_ready        <= (m_edges + 1 == 16);
        end else begin
            if (wrt_en && wrt_index != 4'd0) m_mem[wrt_index] <= wrt_data;
            for (int i = 1; i < 16; i++) begin
                if (ld_issue && ld_index == 4'(i)) m_busy[i] <= 1'b1;
                else if (wrt_en && wrt_index == 4'(i)) m_busy[i] <= 1'b0;
            end
        end
    end

    function automatic logic [31:0] exp_data(input logic [3:0] ix);
        if (!m_ready || ix == 4'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (wrt_en && wrt_index == ix) return wrt_data;
`endif
        return m_mem[ix];
    endfunction

    function automatic logic exp_busy(input logic [3:0] ix);
        if (!m_ready || ix == 4'd0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wrt_en && wrt_index == ix) return 1'b0;
`endif
        return m_busy[ix];
    endfunction

    // Every cycle: DUT against model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("model_rd_data0", {32'h0, rd_data[31:0]},  {32'h0, exp_data(rd_index[3:0])});
        chk("model_rd_data1", {32'h0, rd_data[63:32]}, {32'h0, exp_data(rd_index[7:4])});
        chk("model_rd_busy0", {63'h0, rd_busy[0]}, {63'h0, exp_busy(rd_index[3:0])});
        chk("model_rd_busy1", {63'h0, rd_busy[1]}, {63'h0, exp_busy(rd_index[7:4])});
        chk("model_ready",    {63'h0, ready},      {63'h0, m_ready});
    end

    // ---------------- directed stimulus ----------------
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] d);
        wrt_en = 1'b1; wrt_index = idx; wrt_data = d;
        edge1();
        wrt_en = 1'b0;
    endtask

    task automatic ld(input logic [3:0] idx);
        ld_issue = 1'b1; ld_index = idx;
        edge1();
        ld_issue = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wrt_en = 1'b0; wrt_index = 4'd0; wrt_data = 32'h0;
        ld_issue = 1'b0; ld_index = 4'd0; rd_index = 8'h00;
        repeat (3) edge1();
        chk("reset_ready", {63'h0, ready}, 64'h0);
        chk("reset_busy",  {62'h0, rd_busy}, 64'h0);
        rst_n = 1'b1;
        repeat (16) edge1();
        chk("first_sweep_ready", {63'h0, ready}, 64'h1);

        // Fill with garbage, then reset and verify the sweep clears it.
        for (int i = 1; i < 16; i++) wr(4'(i), 32'hC0DE0000 + 32'(i));
        rd_index = 8'h3C; #1;
        chk("garbage_r12", {32'h0, rd_data[31:0]}, 64'h00000000C0DE000C);
        edge1();
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            chk($sformatf("sweep_ready_e%0d", e), {63'h0, ready}, {63'h0, (e == 16)});
        end
        for (int i = 0; i < 16; i++) begin
            rd_index = {4'(i), 4'(i)}; #1;
            chk($sformatf("sweep_zero_r%0d", i), rd_data, 64'h0);
        end

        // Write / read on both ports simultaneously.
        wr(4'd5, 32'hDEADBEEF);
        rd_index = 8'h55; #1;
        chk("r5_both_ports", rd_data, 64'hDEADBEEF_DEADBEEF);
        wr(4'd0, 32'h00001234);
        rd_index = 8'h00; #1;
        chk("r0_reads_zero", rd_data, 64'h0);

        // Scoreboard.
        ld(4'd7);
        rd_index = 8'h57; #1;
        chk("r7_busy_after_ld", {62'h0, rd_busy}, 64'h1);
        wr(4'd7, 32'h00000077);
        #1;
        chk("r7_clear_after_wb", {62'h0, rd_busy}, 64'h0);
        chk("r7_data", {32'h0, rd_data[31:0]}, 64'h77);
        ld_issue = 1'b1; ld_index = 4'd3;
        wrt_en = 1'b1; wrt_index = 4'd3; wrt_data = 32'h33;
        edge1();
        ld_issue = 1'b0; wrt_en = 1'b0;
        rd_index = 8'h35; #1;
        chk("r3_set_wins", {62'h0, rd_busy}, 64'h2);
        chk("r3_data", {32'h0, rd_data[63:32]}, 64'h33);
        ld(4'd0);
        rd_index = 8'h00; #1;
        chk("r0_never_busy", {62'h0, rd_busy}, 64'h0);

        // Same-cycle write while reading (forwarding when enabled).
        wr(4'd9, 32'h11111111);
        ld(4'd9);
        rd_index = 8'h99;
        wrt_en = 1'b1; wrt_index = 4'd9; wrt_data = 32'hA5A5A5A5;
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle_data", rd_data, 64'hA5A5A5A5_A5A5A5A5);
        chk("bypass_same_cycle_busy", {62'h0, rd_busy}, 64'h0);
`else
        chk("nobypass_same_cycle_data", rd_data, 64'h11111111_11111111);
        chk("nobypass_same_cycle_busy", {62'h0, rd_busy}, 64'h3);
`endif
        edge1();
        wrt_en = 1'b0; #1;
        chk("r9_next_cycle_data", rd_data, 64'hA5A5A5A5_A5A5A5A5);
        chk("r9_next_cycle_busy", {62'h0, rd_busy}, 64'h0);

        // Asynchronous reset in mid-cycle.
        wr(4'd4, 32'h55);
        ld(4'd4);
        rd_index = 8'h44; #1;
        chk("r4_busy_pre_reset", {62'h0, rd_busy}, 64'h3);
        chk("r4_data_pre_reset", rd_data, 64'h00000055_00000055);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_ready", {63'h0, ready}, 64'h0);
        chk("async_reset_busy", {62'h0, rd_busy}, 64'h0);
        edge1();
        rst_n = 1'b1;

        // Writes and load issues during the sweep must be ignored.
        wrt_en = 1'b1; wrt_index = 4'd2; wrt_data = 32'hFF;
        ld_issue = 1'b1; ld_index = 4'd2;
        for (int e = 1; e <= 16; e++) begin
            edge1();
            if (e == 10) begin
                wrt_en = 1'b0; ld_issue = 1'b0;
            end
            chk($sformatf("resweep_ready_e%0d", e), {63'h0, ready}, {63'h0, (e == 16)});
        end
        rd_index = 8'h42; #1;
        chk("lockout_r2_r4_zero", rd_data, 64'h0);
        chk("lockout_busy_zero", {62'h0, rd_busy}, 64'h0);

        repeat (2) edge1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
